// File: rtl/nco_modulator.sv
// rtl/nco_modulator.sv - symbol-driven NCO producing sine-ROM addresses for ASK/FSK/BPSK
module nco_modulator #(
    parameter int SYM_LEN = 64,
    parameter int PHASE_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mode,
    input  logic [PHASE_W-1:0] fcw0,
    input  logic [PHASE_W-1:0] fcw1,
    input  logic               sym_valid,
    input  logic               sym_bit,
    output logic               sym_ready,
    output logic [5:0]         addr,
    output logic               addr_valid,
    output logic               amp_en,
    output logic               busy
);

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYM_LEN - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [1:0] MODE_ASK  = 2'b00;
    localparam logic [1:0] MODE_FSK  = 2'b01;
    localparam logic [1:0] MODE_BPSK = 2'b10;

    logic [0:0]         state;
    logic [PHASE_W-1:0] acc;
    logic [CNT_W-1:0]   cnt;
    logic               bit_l;
    logic [1:0]         mode_l;
    logic [PHASE_W-1:0] fcw0_l;
    logic [PHASE_W-1:0] fcw1_l;

    logic               at_last;
    logic               take;
    logic [PHASE_W-1:0] fcw_sel;
    logic [PHASE_W-1:0] acc_next;
    logic [5:0]         off;
    logic [5:0]         addr_next;
    logic               amp_next;

    always_comb begin
        at_last   = (cnt == CNT_LAST);
        sym_ready = !rst && ((state == S_IDLE) || at_last);
        take      = sym_valid && sym_ready;
        fcw_sel   = (mode_l == MODE_FSK && bit_l) ? fcw1_l : fcw0_l;
        acc_next  = acc + fcw_sel;
        // BPSK phase flip lives only in the address offset so acc stays continuous
        off       = (mode_l == MODE_BPSK && bit_l) ? 6'd32 : 6'd0;
        addr_next = acc_next[PHASE_W-1 -: 6] + off;
        amp_next  = (mode_l == MODE_FSK || mode_l == MODE_BPSK) ? 1'b1 : bit_l;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            acc        <= '0;
            cnt        <= '0;
            addr       <= '0;
            addr_valid <= 1'b0;
            amp_en     <= 1'b0;
            busy       <= 1'b0;
            bit_l      <= 1'b0;
            mode_l     <= MODE_ASK;
            fcw0_l     <= '0;
            fcw1_l     <= '0;
        end else begin
            if (state == S_RUN) begin
                acc        <= acc_next;
                addr       <= addr_next;
                amp_en     <= amp_next;
                addr_valid <= 1'b1;
                cnt        <= cnt + 1'b1;
            end else begin
                addr_valid <= 1'b0;
            end

            // A handshake on the last sample edge chains the next symbol with no gap
            if (take) begin
                bit_l  <= sym_bit;
                mode_l <= mode;
                fcw0_l <= fcw0;
                fcw1_l <= fcw1;
                cnt    <= '0;
                state  <= S_RUN;
                busy   <= 1'b1;
            end else if (state == S_RUN && at_last) begin
                cnt   <= '0;
                state <= S_IDLE;
                busy  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nco_modulator.sv
// tb/tb_nco_modulator.sv - scoreboard bench for nco_modulator
module tb_nco_modulator;

    localparam int SYM_LEN = 64;
    localparam int PHASE_W = 16;

    logic               clk;
    logic               rst;
    logic [1:0]         mode;
    logic [PHASE_W-1:0] fcw0;
    logic [PHASE_W-1:0] fcw1;
    logic               sym_valid;
    logic               sym_bit;
    logic               sym_ready;
    logic [5:0]         addr;
    logic               addr_valid;
    logic               amp_en;
    logic               busy;

    int errors = 0;
    int checks = 0;

    logic [6:0]         exp_q[$];
    logic [PHASE_W-1:0] macc;
    logic [5:0]         last_addr;
    int                 run_len;
    int                 run_max;

    nco_modulator #(.SYM_LEN(SYM_LEN), .PHASE_W(PHASE_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .fcw0       (fcw0),
        .fcw1       (fcw1),
        .sym_valid  (sym_valid),
        .sym_bit    (sym_bit),
        .sym_ready  (sym_ready),
        .addr       (addr),
        .addr_valid (addr_valid),
        .amp_en     (amp_en),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitor: every fresh sample must match the oldest expected one
    always @(negedge clk) begin
        logic [6:0] e;
        if (addr_valid) begin
            run_len = run_len + 1;
            if (run_len > run_max) run_max = run_len;
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_sample: addr=%0d amp_en=%0d with no sample expected", addr, amp_en);
            end else begin
                e = exp_q.pop_front();
                if ({amp_en, addr} !== e) begin
                    errors = errors + 1;
                    $display("FAIL sample: got amp_en=%0d addr=%0d, expected amp_en=%0d addr=%0d",
                             amp_en, addr, e[6], e[5:0]);
                end
            end
        end else begin
            run_len = 0;
        end
    end

    task automatic model_push(input logic b, input logic [1:0] m,
                              input logic [PHASE_W-1:0] f0, input logic [PHASE_W-1:0] f1);
        logic [PHASE_W-1:0] f;
        logic [5:0] a;
        logic amp;
        f   = (m == 2'b01 && b) ? f1 : f0;
        amp = (m == 2'b01 || m == 2'b10) ? 1'b1 : b;
        for (int i = 0; i < SYM_LEN; i++) begin
            macc = macc + f;
            a = macc[PHASE_W-1:PHASE_W-6] + ((m == 2'b10 && b) ? 6'd32 : 6'd0);
            exp_q.push_back({amp, a});
            last_addr = a;
        end
    endtask

    task automatic send_symbol(input logic b, input logic [1:0] m,
                               input logic [PHASE_W-1:0] f0, input logic [PHASE_W-1:0] f1);
        bit done;
        done = 1'b0;
        sym_bit = b; mode = m; fcw0 = f0; fcw1 = f1; sym_valid = 1'b1;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (sym_ready) done = 1'b1;
        end
        checks = checks + 1;
        if (!done) begin
            errors = errors + 1;
            $display("FAIL handshake_timeout: sym_ready=%0d, expected 1 within 300 cycles", sym_ready);
        end else begin
            model_push(b, m, f0, f1);
        end
        @(posedge clk); #1;
        sym_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            @(posedge clk); #2;
            if (busy == 1'b0 && exp_q.size() == 0) done = 1'b1;
        end
        checks = checks + 1;
        if (!done) begin
            errors = errors + 1;
            $display("FAIL idle_timeout: busy=%0d pending=%0d, expected 0 and 0", busy, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; sym_valid = 1'b0; sym_bit = 1'b0; mode = 2'b00; fcw0 = '0; fcw1 = '0;
        macc = '0; run_len = 0; run_max = 0;
        @(posedge clk); #1;
        checks = checks + 1;
        if ({addr, addr_valid, amp_en, busy, sym_ready} !== 10'd0) begin
            errors = errors + 1;
            $display("FAIL reset_outputs: addr=%0d valid=%0d amp=%0d busy=%0d ready=%0d, expected all 0",
                     addr, addr_valid, amp_en, busy, sym_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks = checks + 1;
        if (sym_ready !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL reset_ready_after: sym_ready=%0d, expected 1", sym_ready);
        end
    endtask

    task automatic test_ask();
        run_max = 0;
        send_symbol(1'b1, 2'b00, 16'd1024, 16'd0);
        checks = checks + 1;
        if (addr_valid !== 1'b0 || busy !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL ask_latency0: addr_valid=%0d busy=%0d, expected 0 and 1", addr_valid, busy);
        end
        send_symbol(1'b0, 2'b00, 16'd1024, 16'd0);
        wait_idle();
        checks = checks + 1;
        if (run_max !== 2 * SYM_LEN) begin
            errors = errors + 1;
            $display("FAIL ask_contiguous: run=%0d, expected %0d", run_max, 2 * SYM_LEN);
        end
    endtask

    task automatic test_fsk();
        run_max = 0;
        send_symbol(1'b1, 2'b01, 16'd1024, 16'd2048);
        send_symbol(1'b0, 2'b01, 16'd1024, 16'd2048);
        wait_idle();
        checks = checks + 1;
        if (run_max !== 2 * SYM_LEN) begin
            errors = errors + 1;
            $display("FAIL fsk_contiguous: run=%0d, expected %0d", run_max, 2 * SYM_LEN);
        end
    endtask

    task automatic test_bpsk();
        send_symbol(1'b0, 2'b10, 16'd1024, 16'd0);
        send_symbol(1'b1, 2'b10, 16'd1024, 16'd0);
        wait_idle();
    endtask

    task automatic test_gap();
        send_symbol(1'b1, 2'b00, 16'd1536, 16'd0);
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        checks = checks + 1;
        if (addr !== last_addr || addr_valid !== 1'b0 || busy !== 1'b0 || sym_ready !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL gap_hold: addr=%0d valid=%0d busy=%0d ready=%0d, expected addr=%0d valid=0 busy=0 ready=1",
                     addr, addr_valid, busy, sym_ready, last_addr);
        end
        send_symbol(1'b1, 2'b00, 16'd1024, 16'd0);
        wait_idle();
    endtask

    task automatic test_wrap_latch();
        send_symbol(1'b1, 2'b00, 16'hFC00, 16'd0);
        fcw0 = 16'h0400; fcw1 = 16'h0800; mode = 2'b01; sym_bit = 1'b1;
        wait_idle();
        send_symbol(1'b1, 2'b01, 16'h0400, 16'h0800);
        wait_idle();
    endtask

    task automatic test_back_to_back_reset();
        send_symbol(1'b1, 2'b00, 16'd1024, 16'd0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checks = checks + 1;
        if (sym_ready !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL midrst_ready: sym_ready=%0d, expected 0", sym_ready);
        end
        @(posedge clk); #1;
        exp_q.delete();
        macc = '0;
        checks = checks + 1;
        if ({addr, addr_valid, amp_en, busy} !== 9'd0) begin
            errors = errors + 1;
            $display("FAIL midrst_outputs: addr=%0d valid=%0d amp=%0d busy=%0d, expected all 0",
                     addr, addr_valid, amp_en, busy);
        end
        @(posedge clk); #1;
        checks = checks + 1;
        if (sym_ready !== 1'b0 || busy !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL midrst_hold: sym_ready=%0d busy=%0d, expected 0 and 0", sym_ready, busy);
        end
        rst = 1'b0;
        #1;
        checks = checks + 1;
        if (sym_ready !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL midrst_ready_after: sym_ready=%0d, expected 1", sym_ready);
        end
        send_symbol(1'b1, 2'b00, 16'd1024, 16'd0);
        @(posedge clk); #1;
        checks = checks + 1;
        if (addr !== 6'd1) begin
            errors = errors + 1;
            $display("FAIL midrst_restart: addr=%0d, expected 1", addr);
        end
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_ask();
        test_fsk();
        test_bpsk();
        test_gap();
        test_wrap_latch();
        test_back_to_back_reset();
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
